// File: rtl/act_hold_ctrl.sv
// rtl/act_hold_ctrl.sv - per-channel read strobe with periodic or retriggerable timeout hold
module act_hold_ctrl #(
  parameter int NCH    = 4,
  parameter int CNT_W  = 16,
  parameter int NCNT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    en,
  input  logic              mode,
  input  logic [CNT_W-1:0]  hold_len,
  output logic [NCH-1:0]    rd,
  output logic              act,
  output logic [NCH-1:0]    rise,
  output logic [NCH-1:0]    fall,
  output logic [NCNT_W-1:0] n_active
);

  // Logical per-channel state, derived from the strobe register and the request.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } ch_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NCH-1:0]            rd_q,   rd_d;
  logic [NCH-1:0]            rise_q, rise_d;
  logic [NCH-1:0]            fall_q, fall_d;
  logic [NCH-1:0][CNT_W-1:0] cnt_q,  cnt_d;
  logic [NCNT_W-1:0]         n_active_c;
  ch_state_e                 ch_state [NCH];

  // Decode each channel's logical state; the strobe alone says IDLE vs busy.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_state[i] = ST_IDLE;
      if (rd_q[i]) begin
        ch_state[i] = en[i] ? ST_ACTIVE : ST_HOLD;
      end
    end
  end

  // Next-state for strobe and hold counter; a high request always wins over release.
  always_comb begin
    rd_d  = rd_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NCH; i++) begin
      case (ch_state[i])
        ST_IDLE: begin
          // Periodic mode keeps the retained count across idle periods.
          if (en[i]) begin
            rd_d[i] = 1'b1;
            if (mode) begin
              cnt_d[i] = '0;
            end
          end
        end
        ST_ACTIVE: begin
          // Timeout mode restarts on every request; periodic mode keeps counting.
          if (mode) begin
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (!mode) begin
            // Release only at the wrap point; the counter wraps to zero with it.
            cnt_d[i] = cnt_q[i] + CNT_ONE;
            if (cnt_q[i] == CNT_MAX) begin
              rd_d[i] = 1'b0;
            end
          end else if (cnt_q[i] >= hold_len) begin
            // >= so a lowered hold_len (or a mode switch) releases at once.
            rd_d[i]  = 1'b0;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          rd_d[i]  = 1'b0;
          cnt_d[i] = '0;
        end
      endcase
    end
    rise_d = rd_d & ~rd_q;
    fall_d = rd_q & ~rd_d;
  end

  // State registers; reset clears pulses too, so leaving reset never emits a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      cnt_q  <= '0;
    end else begin
      rd_q   <= rd_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  // Population count of active strobes, straight off the registers.
  always_comb begin
    n_active_c = '0;
    for (int i = 0; i < NCH; i++) begin
      n_active_c = n_active_c + NCNT_W'(rd_q[i]);
    end
  end

  assign rd       = rd_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign act      = |rd_q;
  assign n_active = n_active_c;

endmodule
